// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract built from one shared 17-bit adder, stepped one 16-bit word
// per cycle from the least-significant word up, with the carry chained through a register.
module multiword_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [16*WORDS-1:0] a_in,
  input  logic [16*WORDS-1:0] b_in,
  output logic                busy,
  output logic                done,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf
);

  localparam int W  = 16;
  localparam int N  = W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic          carry_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  sum_q;
  logic          busy_q;
  logic          done_q;
  logic          cout_q;
  logic          ovf_q;

  logic [W-1:0]  a_word_d;
  logic [W-1:0]  b_word_d;
  logic [W:0]    word_sum_d;
  logic          ovf_d;

  // Word slice at idx_q through the shared adder; ovf_d only matters on the top word.
  always_comb begin
    a_word_d   = a_q[idx_q*W +: W];
    b_word_d   = b_q[idx_q*W +: W];
    word_sum_d = {1'b0, a_word_d} + {1'b0, b_word_d} + {16'h0000, carry_q};
    ovf_d      = (a_word_d[W-1] == b_word_d[W-1]) && (word_sum_d[W-1] != a_word_d[W-1]);
  end

  // Control FSM and datapath registers; B is stored pre-inverted for subtraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_in;
            b_q     <= sub ? ~b_in : b_in;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          sum_q[idx_q*W +: W] <= word_sum_d[W-1:0];
          carry_q             <= word_sum_d[W];
          if (idx_q == LAST_IDX) begin
            cout_q  <= word_sum_d[W];
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench: a 4-word instance (directed table, hand sequences, random ops)
// and a 1-word instance (random back-to-back ops), both against an arithmetic model.
module tb_multiword_add_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s4_start = 1'b0, s4_sub = 1'b0, s4_cin = 1'b0;
  logic [63:0] s4_a = '0, s4_b = '0, s4_sum;
  logic        s4_busy, s4_done, s4_cout, s4_ovf;

  logic        s1_start = 1'b0, s1_sub = 1'b0, s1_cin = 1'b0;
  logic [15:0] s1_a = '0, s1_b = '0, s1_sum;
  logic        s1_busy, s1_done, s1_cout, s1_ovf;

  multiword_add_sequencer #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .cin(s4_cin),
    .a_in(s4_a), .b_in(s4_b), .busy(s4_busy), .done(s4_done), .sum(s4_sum),
    .cout(s4_cout), .ovf(s4_ovf)
  );

  multiword_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .cin(s1_cin),
    .a_in(s1_a), .b_in(s1_b), .busy(s1_busy), .done(s1_done), .sum(s1_sum),
    .cout(s1_cout), .ovf(s1_ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on nb-bit operands; overflow = exact signed
  // result not representable in nb bits.
  function automatic void model(input int nb, input logic s, input logic c,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] sm, output logic co, output logic ov);
    logic [64:0] r;
    logic [63:0] mask;
    logic signed [66:0] sa, sb, ss, ex, span;
    mask = (nb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nb) - 64'd1);
    if (s) begin
      sm = (a - b) & mask;
      co = (a >= b);
    end else begin
      r  = {1'b0, a} + {1'b0, b} + {64'd0, c};
      sm = r[63:0] & mask;
      co = r[nb];
    end
    span = 67'sd1 <<< nb;
    sa = $signed({3'b000, a});  if (a[nb-1])  sa = sa - span;
    sb = $signed({3'b000, b});  if (b[nb-1])  sb = sb - span;
    ss = $signed({3'b000, sm}); if (sm[nb-1]) ss = ss - span;
    ex = s ? (sa - sb) : (sa + sb + $signed({66'd0, c}));
    ov = (ex != ss);
  endfunction

  // Called just after an edge: presents an op, accepts it, then scrambles the inputs.
  task automatic start4(input logic s, input logic c, input logic [63:0] a, input logic [63:0] b);
    s4_sub = s; s4_cin = c; s4_a = a; s4_b = b; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    s4_a = {$urandom(), $urandom()};
    s4_b = {$urandom(), $urandom()};
    s4_sub = ~s; s4_cin = ~c;
  endtask

  task automatic wait4(output int cyc, output int busy_lo);
    cyc = 0; busy_lo = 0;
    while (s4_done !== 1'b1 && cyc < 20) begin
      if (s4_busy !== 1'b1) busy_lo++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic op4(input string nm, input logic s, input logic c,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] es, input logic ec, input logic eo);
    int cyc, bl;
    start4(s, c, a, b);
    wait4(cyc, bl);
    chk({nm, " latency"}, 64'(cyc), 64'd4);
    chk({nm, " busy gaps"}, 64'(bl), 64'd0);
    chk({nm, " busy at done"}, {63'd0, s4_busy}, 64'd0);
    chk({nm, " sum"}, s4_sum, es);
    chk({nm, " cout"}, {63'd0, s4_cout}, {63'd0, ec});
    chk({nm, " ovf"}, {63'd0, s4_ovf}, {63'd0, eo});
  endtask

  initial begin
    logic [63:0] a, b, es;
    logic ec, eo, s, c;
    int cyc, bl, dcount;

    vecs[0] = '{1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 64'h7, 64'h5, 64'h2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 64'h1234, 64'h1234, 64'h0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0000_FFFF_0000, 64'h0001_0000_0000_0000, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {63'd0, s4_busy}, 64'd0);
    chk("reset done", {63'd0, s4_done}, 64'd0);
    chk("reset sum", s4_sum, 64'd0);
    chk("reset cout/ovf", {62'd0, s4_cout, s4_ovf}, 64'd0);
    chk("reset w1 outputs", {45'd0, s1_busy, s1_done, s1_cout, s1_ovf, s1_sum}, 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      op4($sformatf("vec%0d", i), vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b,
          vecs[i].sum, vecs[i].cout, vecs[i].ovf);

    // start pulsed mid-run is ignored; the original operands win
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_2222_3333_4444;
    model(64, 1'b0, 1'b1, a, b, es, ec, eo);
    start4(1'b0, 1'b1, a, b);
    @(posedge clk); #1;
    s4_a = 64'hDEAD_BEEF_DEAD_BEEF; s4_b = 64'h5; s4_sub = 1'b1; s4_start = 1'b1;
    @(posedge clk); #1;
    s4_start = 1'b0;
    wait4(cyc, bl);
    chk("midrun remaining latency", 64'(cyc), 64'd2);
    chk("midrun sum", s4_sum, es);
    chk("midrun cout/ovf", {62'd0, s4_cout, s4_ovf}, {62'd0, ec, eo});

    // start in the done cycle: back-to-back, done pulse only one cycle wide
    a = 64'h0000_0000_0000_0010; b = 64'h0000_0000_0000_0020;
    model(64, 1'b1, 1'b0, a, b, es, ec, eo);
    start4(1'b1, 1'b0, a, b);
    chk("b2b done cleared", {63'd0, s4_done}, 64'd0);
    chk("b2b sum cleared", s4_sum, 64'd0);
    wait4(cyc, bl);
    chk("b2b latency", 64'(cyc), 64'd4);
    chk("b2b sum", s4_sum, es);
    chk("b2b cout/ovf", {62'd0, s4_cout, s4_ovf}, {62'd0, ec, eo});
    @(posedge clk); #1;
    chk("b2b done one cycle", {63'd0, s4_done}, 64'd0);
    chk("b2b result held", s4_sum, es);

    // asynchronous reset during word 2 abandons the op
    start4(1'b0, 1'b0, 64'h1111_2222_3333_4444, 64'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset busy", {63'd0, s4_busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", {63'd0, s4_busy}, 64'd0);
    chk("async rst done", {63'd0, s4_done}, 64'd0);
    chk("async rst sum", s4_sum, 64'd0);
    chk("async rst cout/ovf", {62'd0, s4_cout, s4_ovf}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    dcount = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (s4_done === 1'b1) dcount++;
    end
    chk("no done after reset", 64'(dcount), 64'd0);
    model(64, 1'b0, 1'b1, 64'hAAAA_5555_FFFF_0001, 64'h5555_AAAA_0000_FFFF, es, ec, eo);
    op4("post-reset", 1'b0, 1'b1, 64'hAAAA_5555_FFFF_0001, 64'h5555_AAAA_0000_FFFF, es, ec, eo);

    for (int i = 0; i < 40; i++) begin
      a = {$urandom(), $urandom()};
      b = (i % 5 == 0) ? a : {$urandom(), $urandom()};
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      model(64, s, c, a, b, es, ec, eo);
      op4($sformatf("rnd4_%0d", i), s, c, a, b, es, ec, eo);
    end

    // 1-word instance: each op starts in the done cycle of the previous one
    for (int i = 0; i < 1000; i++) begin
      a = {48'd0, 16'($urandom_range(0, 65535))};
      b = {48'd0, 16'($urandom_range(0, 65535))};
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      model(16, s, c, a, b, es, ec, eo);
      s1_a = a[15:0]; s1_b = b[15:0]; s1_sub = s; s1_cin = c; s1_start = 1'b1;
      @(posedge clk); #1;
      s1_start = 1'b0;
      s1_a = 16'($urandom()); s1_b = 16'($urandom()); s1_sub = ~s; s1_cin = ~c;
      chk("w1 busy", {62'd0, s1_busy, s1_done}, 64'd2);
      @(posedge clk); #1;
      chk("w1 done", {62'd0, s1_busy, s1_done}, 64'd1);
      chk("w1 sum", {48'd0, s1_sum}, es);
      chk("w1 cout/ovf", {62'd0, s1_cout, s1_ovf}, {62'd0, ec, eo});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
